// File: rtl/mem_access.sv
// Memory-access stage: accepts execute results, runs single-outstanding data-memory
// transactions, and drives one registered register-file write-back port.
module mem_access #(
    parameter int unsigned ADDR_W      = 32,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       result,
    input  logic              mem_read_enabled,
    input  logic              mem_write_enabled,
    input  logic [ADDR_W-1:0] mem_write_dest,
    input  logic [31:0]       mem_write_data,
    input  logic              reg_write_enabled,
    input  logic [4:0]        reg_write_dest,
    output logic              d_req_valid,
    input  logic              d_req_ready,
    output logic              d_req_we,
    output logic [ADDR_W-1:0] d_req_addr,
    output logic [31:0]       d_req_wdata,
    input  logic              d_resp_valid,
    input  logic [31:0]       d_resp_rdata,
    output logic              wb_enabled,
    output logic [4:0]        wb_dest,
    output logic [31:0]       wb_data,
    output logic              misaligned
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t              state_q, state_d;
    logic                d_req_valid_q, d_req_valid_d;
    logic                d_req_we_q, d_req_we_d;
    logic [ADDR_W-1:0]   d_req_addr_q, d_req_addr_d;
    logic [31:0]         d_req_wdata_q, d_req_wdata_d;
    logic                wb_enabled_q, wb_enabled_d;
    logic [4:0]          wb_dest_q, wb_dest_d;
    logic [31:0]         wb_data_q, wb_data_d;
    logic                misaligned_q, misaligned_d;
    logic [4:0]          ld_dest_q, ld_dest_d;

    assign in_ready = (state_q == IDLE);

    always_comb begin
        state_d       = state_q;
        d_req_valid_d = d_req_valid_q;
        d_req_we_d    = d_req_we_q;
        d_req_addr_d  = d_req_addr_q;
        d_req_wdata_d = d_req_wdata_q;
        wb_enabled_d  = 1'b0;
        wb_dest_d     = wb_dest_q;
        wb_data_d     = wb_data_q;
        misaligned_d  = 1'b0;
        ld_dest_d     = ld_dest_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (mem_read_enabled || mem_write_enabled) begin
                        if (CHECK_ALIGN && (mem_write_dest[1:0] != 2'b00)) begin
                            misaligned_d = 1'b1;
                        end else begin
                            // read takes priority when both enables are set
                            state_d       = REQ;
                            d_req_valid_d = 1'b1;
                            d_req_we_d    = !mem_read_enabled;
                            d_req_addr_d  = mem_write_dest;
                            if (!mem_read_enabled) begin
                                d_req_wdata_d = mem_write_data;
                            end
                            ld_dest_d = reg_write_enabled ? reg_write_dest : '0;
                        end
                    end else if (reg_write_enabled && (reg_write_dest != '0)) begin
                        wb_enabled_d = 1'b1;
                        wb_dest_d    = reg_write_dest;
                        wb_data_d    = result;
                    end
                end
            end
            REQ: begin
                if (d_req_ready) begin
                    d_req_valid_d = 1'b0;
                    state_d       = d_req_we_q ? IDLE : RESP;
                end
            end
            RESP: begin
                if (d_resp_valid) begin
                    state_d = IDLE;
                    if (ld_dest_q != '0) begin
                        wb_enabled_d = 1'b1;
                        wb_dest_d    = ld_dest_q;
                        wb_data_d    = d_resp_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            d_req_valid_q <= 1'b0;
            d_req_we_q    <= 1'b0;
            d_req_addr_q  <= '0;
            d_req_wdata_q <= '0;
            wb_enabled_q  <= 1'b0;
            wb_dest_q     <= '0;
            wb_data_q     <= '0;
            misaligned_q  <= 1'b0;
            ld_dest_q     <= '0;
        end else begin
            state_q       <= state_d;
            d_req_valid_q <= d_req_valid_d;
            d_req_we_q    <= d_req_we_d;
            d_req_addr_q  <= d_req_addr_d;
            d_req_wdata_q <= d_req_wdata_d;
            wb_enabled_q  <= wb_enabled_d;
            wb_dest_q     <= wb_dest_d;
            wb_data_q     <= wb_data_d;
            misaligned_q  <= misaligned_d;
            ld_dest_q     <= ld_dest_d;
        end
    end

    assign d_req_valid = d_req_valid_q;
    assign d_req_we    = d_req_we_q;
    assign d_req_addr  = d_req_addr_q;
    assign d_req_wdata = d_req_wdata_q;
    assign wb_enabled  = wb_enabled_q;
    assign wb_dest     = wb_dest_q;
    assign wb_data     = wb_data_q;
    assign misaligned  = misaligned_q;

endmodule
